// File: rtl/servo_pwm_driver_pkg.sv
// Shared constants and state encoding for the servo pulse driver.
package servo_pkg;

  // Width of the arm position word delivered by the position counter
  localparam int POS_W = 11;

  // Default timing, in clkout cycles (1 MHz clkout gives a 20 ms frame)
  localparam int DEF_PERIOD    = 20000;
  localparam int DEF_MIN_PULSE = 1000;
  localparam int DEF_RANGE     = 1000;
  localparam int DEF_STEP      = 16;
  localparam int DEF_INIT      = 500;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/servo_pwm_driver_if.sv
// Position-in / pulse-out bundle between the position counter and the servo driver.
interface servo_pwm_driver_if;
  import servo_pkg::*;

  logic             en;
  logic [POS_W-1:0] pos;
  logic             servo_pwm;
  logic             frame_tick;
  logic [POS_W-1:0] cur_off;
  logic             at_target;

  // Position source side
  modport master (
    output en, pos,
    input  servo_pwm, frame_tick, cur_off, at_target
  );

  // Driver side
  modport slave (
    input  en, pos,
    output servo_pwm, frame_tick, cur_off, at_target
  );
endinterface

// File: rtl/servo_pwm_driver_slew.sv
// Clamps the requested position to RANGE and moves the current offset
// at most STEP toward it. Purely combinational; the caller registers it.
module servo_slew
  import servo_pkg::*;
#(
  parameter int RANGE = DEF_RANGE,
  parameter int STEP  = DEF_STEP
) (
  input  logic [POS_W-1:0] pos_i,
  input  logic [POS_W-1:0] cur_off_i,
  output logic [POS_W-1:0] target_o,
  output logic [POS_W-1:0] next_off_o
);
  // One extra bit so cur+STEP never wraps before the compare
  localparam int W = POS_W + 1;

  logic [W-1:0] tgt_w, cur_w, diff_w, next_w;

  // Clamp, then step toward the clamped target
  always_comb begin
    target_o = (pos_i > POS_W'(RANGE)) ? POS_W'(RANGE) : pos_i;
    tgt_w    = {1'b0, target_o};
    cur_w    = {1'b0, cur_off_i};
    diff_w   = '0;
    next_w   = cur_w;
    if (tgt_w >= cur_w) begin
      diff_w = tgt_w - cur_w;
      next_w = (diff_w <= W'(STEP)) ? tgt_w : cur_w + W'(STEP);
    end else begin
      diff_w = cur_w - tgt_w;
      next_w = (diff_w <= W'(STEP)) ? tgt_w : cur_w - W'(STEP);
    end
    next_off_o = POS_W'(next_w);
  end
endmodule

// File: rtl/servo_pwm_driver.sv
// Servo pulse-train generator: one pulse of MIN_PULSE+cur_off cycles per
// PERIOD-cycle frame, with the offset slew-limited once per frame.
module servo_pwm_driver
  import servo_pkg::*;
#(
  parameter int PERIOD    = DEF_PERIOD,
  parameter int MIN_PULSE = DEF_MIN_PULSE,
  parameter int RANGE     = DEF_RANGE,
  parameter int STEP      = DEF_STEP,
  parameter int INIT      = DEF_INIT
) (
  input  logic               clkout,
  input  logic               rst,
  servo_pwm_driver_if.slave  bus
);
  localparam int FCNT_W = $clog2(PERIOD);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(PERIOD - 1);

  state_e            state_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic [POS_W-1:0]  cur_off_q, target_q;
  logic              servo_pwm_q, frame_tick_q, at_target_q;

  logic [POS_W-1:0]  target_d, cur_off_d;
  logic [FCNT_W-1:0] hi_last;
  logic              frame_start;

  servo_slew #(.RANGE(RANGE), .STEP(STEP)) u_slew (
    .pos_i      (bus.pos),
    .cur_off_i  (cur_off_q),
    .target_o   (target_d),
    .next_off_o (cur_off_d)
  );

  // Last high cycle of the pulse; cur_off <= RANGE keeps this inside the frame
  assign hi_last = FCNT_W'(MIN_PULSE) + FCNT_W'(cur_off_q) - FCNT_W'(1);

  // A new frame begins from idle, or back-to-back at the end of a frame
  assign frame_start = bus.en &&
                       ((state_q == ST_OFF) || (state_q == ST_LOW && fcnt_q == FCNT_LAST));

  // Frame counter, pulse FSM and per-frame sampling of position/slew
  always_ff @(posedge clkout) begin
    if (rst) begin
      state_q      <= ST_OFF;
      fcnt_q       <= '0;
      cur_off_q    <= POS_W'(INIT);
      target_q     <= POS_W'(INIT);
      servo_pwm_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      at_target_q  <= 1'b1;
    end else begin
      frame_tick_q <= 1'b0;
      if (frame_start) begin
        state_q      <= ST_HIGH;
        fcnt_q       <= '0;
        target_q     <= target_d;
        cur_off_q    <= cur_off_d;
        at_target_q  <= (cur_off_d == target_d);
        servo_pwm_q  <= 1'b1;
        frame_tick_q <= 1'b1;
      end else begin
        case (state_q)
          ST_OFF: fcnt_q <= '0;
          ST_HIGH: begin
            fcnt_q <= fcnt_q + 1'b1;
            if (fcnt_q == hi_last) begin
              state_q     <= ST_LOW;
              servo_pwm_q <= 1'b0;
            end
          end
          ST_LOW: begin
            // Frame end with en low: drop to idle instead of restarting
            if (fcnt_q == FCNT_LAST) begin
              state_q <= ST_OFF;
              fcnt_q  <= '0;
            end else begin
              fcnt_q <= fcnt_q + 1'b1;
            end
          end
          default: begin
            state_q     <= ST_OFF;
            fcnt_q      <= '0;
            servo_pwm_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.servo_pwm  = servo_pwm_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.cur_off    = cur_off_q;
  assign bus.at_target  = at_target_q;
endmodule

// File: doc/servo_pwm_driver.md
Name: servo_pwm_driver

Overview:
- Consumes the 11-bit arm position value produced by the button-driven position counter.
- Generates the servo control pulse train for one joint of the robotic arm.
- Each fixed-length frame emits one high pulse whose width is MIN_PULSE plus the slew-limited position.
- Sits between the position counter and the servo output pin; runs in the divided clkout domain.

Parameters:
- PERIOD, 20000: frame length in clkout cycles (20 ms at 1 MHz clkout).
- MIN_PULSE, 1000: pulse width in cycles for position 0.
- RANGE, 1000: maximum position offset; pos above RANGE clamps to RANGE.
- STEP, 16: maximum change of the current offset per frame (slew limit).
- INIT, 500: current offset after reset (arm centre).

Ports:
- clkout  input  1  divided system clock.
- rst  input  1  synchronous, active-high reset, sampled on clkout.
- en  input  1  enable pulse generation.
- pos  input  11  requested position from the position counter.
- servo_pwm  output  1  servo pulse, registered.
- frame_tick  output  1  one-cycle pulse in the first cycle of every frame.
- cur_off  output  11  current slew-limited offset (0..RANGE).
- at_target  output  1  high when cur_off equals the clamped target.

Behaviour:
- Reset values:
  - state=OFF, fcnt=0, cur_off=INIT, target=INIT.
  - servo_pwm=0, frame_tick=0, at_target=1.
- States:
  - OFF: fcnt held 0, servo_pwm=0.
  - HIGH: pulse active.
  - LOW: remainder of frame.
- OFF->HIGH: on a clock edge with en=1. That edge is a frame-start edge.
- Frame-start edge (OFF->HIGH, or LOW at fcnt==PERIOD-1 with en=1):
  - target <= min(pos, RANGE).
  - cur_off <= slew result (see below).
  - fcnt <= 0.
  - frame_tick <= 1.
- Slew: d = target - cur_off using the newly sampled target.
  - |d| <= STEP: cur_off = target.
  - Otherwise cur_off moves STEP toward target.
  - Arithmetic is unsigned with 12-bit intermediates; no wrap.
- Within a frame:
  - fcnt increments every cycle.
  - servo_pwm=1 exactly for fcnt in [0, MIN_PULSE+cur_off-1]; HIGH->LOW when fcnt reaches MIN_PULSE+cur_off-1.
  - The frame is exactly PERIOD cycles long.
- pos is sampled only at frame-start edges. Mid-frame changes affect the next frame only; the pulse never glitches or truncates.
- en deasserted mid-frame: the current frame completes unchanged, then LOW->OFF at fcnt==PERIOD-1. No frame_tick is emitted.
- en reasserted while in OFF: a new frame starts on the next edge.
- at_target = (cur_off == target). It is registered and updates with cur_off.
- rst at any time, including mid-pulse: all registers return to reset values on that edge, so servo_pwm=0 from the next cycle.
- Legal configuration constraints:
  - MIN_PULSE + RANGE < PERIOD.
  - STEP >= 1.
  - fcnt width = clog2(PERIOD).

Decomposition:
- Package servo_pkg holds:
  - Default timing constants: PERIOD, MIN_PULSE, RANGE, STEP, INIT.
  - State encoding: OFF, HIGH, LOW.
  - Position width constant (11).
- One sub-module, servo_slew: combinational clamp and step of target/cur_off → next cur_off.
- Counter and FSM stay in the top level.

Test Plan (bench overrides PERIOD=100, MIN_PULSE=10, RANGE=50, STEP=5, INIT=25):
- rst, then en=1 with pos=25 → servo_pwm high 35 cycles, low 65; frame_tick every 100 cycles; at_target=1.
- From cur_off=25, pos=2047 → target clamps to 50; high widths 40,45,50,55,60 over 5 frames; at_target rises after frame 5; cur_off=50.
- From cur_off=50, pos=0 → widths 55,50,...,10 over frames 1-10; cur_off=0.
- pos changed from 25 to 50 at fcnt=5 of a frame → current pulse stays 35; next frame is 40.
- en dropped at fcnt=20 → frame finishes at cycle 100, then servo_pwm=0 with no frame_tick; en=1 again → frame_tick on the next cycle.
- rst asserted at fcnt=15 while high → servo_pwm=0 next cycle; cur_off=25; state OFF.
